// File: rtl/ex_operand_stage.sv
// EX operand stage: ID/EX pipeline register with operand forwarding,
// ALU source selection and load-use hazard detection.
module ex_operand_stage (
    input  logic        clk,
    input  logic        rst_n,

    // ID-side inputs
    input  logic        id_valid,
    input  logic [4:0]  id_rs1_addr,
    input  logic [4:0]  id_rs2_addr,
    input  logic [4:0]  id_rd_addr,
    input  logic [31:0] id_rs1_data,
    input  logic [31:0] id_rs2_data,
    input  logic [31:0] id_imm,
    input  logic [31:0] id_pc,
    input  logic [2:0]  id_alu_ctrl,
    input  logic        id_alu_src_a,
    input  logic        id_alu_src_b,
    input  logic        id_reg_write,
    input  logic        id_mem_read,
    input  logic        id_mem_write,

    // Pipeline control
    input  logic        stall,
    input  logic        flush,

    // Forwarding sources
    input  logic [4:0]  exmem_rd,
    input  logic        exmem_reg_write,
    input  logic [31:0] exmem_result,
    input  logic [4:0]  memwb_rd,
    input  logic        memwb_reg_write,
    input  logic [31:0] memwb_result,

    // To ALU / downstream
    output logic [31:0] SrcA,
    output logic [31:0] SrcB,
    output logic [2:0]  ALUControl,
    output logic        ex_valid,
    output logic [4:0]  ex_rd,
    output logic        ex_reg_write,
    output logic        ex_mem_read,
    output logic        ex_mem_write,
    output logic [31:0] ex_store_data,
    output logic        load_use_hold
);

    typedef struct packed {
        logic        valid;
        logic [4:0]  rs1_addr;
        logic [4:0]  rs2_addr;
        logic [4:0]  rd;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [2:0]  alu_ctrl;
        logic        alu_src_a;
        logic        alu_src_b;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
    } stage_t;

    stage_t stage_q, stage_d;

    logic [31:0] fwd_a;
    logic [31:0] fwd_b;

    // Load in EX whose destination is read by the instruction in ID
    always_comb begin
        load_use_hold = stage_q.valid & stage_q.mem_read & (stage_q.rd != 5'd0) & id_valid &
                        ((id_rs1_addr == stage_q.rd) | (id_rs2_addr == stage_q.rd));
    end

    // Next-state: flush > stall > load-use bubble > normal capture
    always_comb begin
        stage_d = stage_q;
        if (flush) begin
            stage_d = '0;
        end else if (stall) begin
            stage_d = stage_q;
        end else if (load_use_hold) begin
            stage_d = '0;
        end else begin
            stage_d.valid     = id_valid;
            stage_d.rs1_addr  = id_rs1_addr;
            stage_d.rs2_addr  = id_rs2_addr;
            stage_d.rd        = id_rd_addr;
            stage_d.rs1_data  = id_rs1_data;
            stage_d.rs2_data  = id_rs2_data;
            stage_d.imm       = id_imm;
            stage_d.pc        = id_pc;
            stage_d.alu_ctrl  = id_alu_ctrl;
            stage_d.alu_src_a = id_alu_src_a;
            stage_d.alu_src_b = id_alu_src_b;
            // Invalid slots must not produce side effects downstream
            stage_d.reg_write = id_reg_write & id_valid;
            stage_d.mem_read  = id_mem_read & id_valid;
            stage_d.mem_write = id_mem_write & id_valid;
        end
    end

    // ID/EX pipeline register, asynchronously cleared
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    // Operand forwarding: EX/MEM wins over MEM/WB; x0 is never forwarded
    always_comb begin
        fwd_a = stage_q.rs1_data;
        if (exmem_reg_write && (exmem_rd != 5'd0) && (exmem_rd == stage_q.rs1_addr)) begin
            fwd_a = exmem_result;
        end else if (memwb_reg_write && (memwb_rd != 5'd0) &&
                     (memwb_rd == stage_q.rs1_addr)) begin
            fwd_a = memwb_result;
        end

        fwd_b = stage_q.rs2_data;
        if (exmem_reg_write && (exmem_rd != 5'd0) && (exmem_rd == stage_q.rs2_addr)) begin
            fwd_b = exmem_result;
        end else if (memwb_reg_write && (memwb_rd != 5'd0) &&
                     (memwb_rd == stage_q.rs2_addr)) begin
            fwd_b = memwb_result;
        end
    end

    // ALU source muxes and direct register outputs
    always_comb begin
        SrcA          = stage_q.alu_src_a ? stage_q.pc : fwd_a;
        SrcB          = stage_q.alu_src_b ? stage_q.imm : fwd_b;
        ex_store_data = fwd_b;
        ALUControl    = stage_q.alu_ctrl;
        ex_valid      = stage_q.valid;
        ex_rd         = stage_q.rd;
        ex_reg_write  = stage_q.reg_write;
        ex_mem_read   = stage_q.mem_read;
        ex_mem_write  = stage_q.mem_write;
    end

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed self-checking bench for ex_operand_stage.
module tb_ex_operand_stage;

    logic        clk;
    logic        rst_n;
    logic        id_valid;
    logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
    logic [31:0] id_rs1_data, id_rs2_data, id_imm, id_pc;
    logic [2:0]  id_alu_ctrl;
    logic        id_alu_src_a, id_alu_src_b, id_reg_write, id_mem_read, id_mem_write;
    logic        stall, flush;
    logic [4:0]  exmem_rd, memwb_rd;
    logic        exmem_reg_write, memwb_reg_write;
    logic [31:0] exmem_result, memwb_result;
    logic [31:0] SrcA, SrcB, ex_store_data;
    logic [2:0]  ALUControl;
    logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, load_use_hold;
    logic [4:0]  ex_rd;

    int n_pass;
    int n_total;

    ex_operand_stage dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .id_valid        (id_valid),
        .id_rs1_addr     (id_rs1_addr),
        .id_rs2_addr     (id_rs2_addr),
        .id_rd_addr      (id_rd_addr),
        .id_rs1_data     (id_rs1_data),
        .id_rs2_data     (id_rs2_data),
        .id_imm          (id_imm),
        .id_pc           (id_pc),
        .id_alu_ctrl     (id_alu_ctrl),
        .id_alu_src_a    (id_alu_src_a),
        .id_alu_src_b    (id_alu_src_b),
        .id_reg_write    (id_reg_write),
        .id_mem_read     (id_mem_read),
        .id_mem_write    (id_mem_write),
        .stall           (stall),
        .flush           (flush),
        .exmem_rd        (exmem_rd),
        .exmem_reg_write (exmem_reg_write),
        .exmem_result    (exmem_result),
        .memwb_rd        (memwb_rd),
        .memwb_reg_write (memwb_reg_write),
        .memwb_result    (memwb_result),
        .SrcA            (SrcA),
        .SrcB            (SrcB),
        .ALUControl      (ALUControl),
        .ex_valid        (ex_valid),
        .ex_rd           (ex_rd),
        .ex_reg_write    (ex_reg_write),
        .ex_mem_read     (ex_mem_read),
        .ex_mem_write    (ex_mem_write),
        .ex_store_data   (ex_store_data),
        .load_use_hold   (load_use_hold)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 ns after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_valid = 0; id_rs1_addr = 0; id_rs2_addr = 0; id_rd_addr = 0;
        id_rs1_data = 0; id_rs2_data = 0; id_imm = 0; id_pc = 0; id_alu_ctrl = 0;
        id_alu_src_a = 0; id_alu_src_b = 0; id_reg_write = 0; id_mem_read = 0;
        id_mem_write = 0; stall = 0; flush = 0;
        exmem_rd = 0; exmem_reg_write = 0; exmem_result = 0;
        memwb_rd = 0; memwb_reg_write = 0; memwb_result = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        id_valid = 1; id_rs1_data = 32'h1234; id_reg_write = 1; id_rd_addr = 5'd3;
        rst_n = 0;
        step();
        n_total++; if (ex_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", ex_valid); else n_pass++;
        n_total++; if (SrcA !== 32'h0) $display("FAIL reset_srca: got %h want 0", SrcA); else n_pass++;
        n_total++; if (SrcB !== 32'h0) $display("FAIL reset_srcb: got %h want 0", SrcB); else n_pass++;
        n_total++; if (ALUControl !== 3'b000) $display("FAIL reset_aluctrl: got %b want 000", ALUControl); else n_pass++;
        n_total++; if (ex_rd !== 5'd0) $display("FAIL reset_rd: got %0d want 0", ex_rd); else n_pass++;
        n_total++; if (ex_reg_write !== 1'b0) $display("FAIL reset_regwrite: got %b want 0", ex_reg_write); else n_pass++;
        n_total++; if (ex_store_data !== 32'h0) $display("FAIL reset_store: got %h want 0", ex_store_data); else n_pass++;
        n_total++; if (load_use_hold !== 1'b0) $display("FAIL reset_luh: got %b want 0", load_use_hold); else n_pass++;
        #2 rst_n = 1;
        clear_inputs();
    endtask

    task automatic test_plain_capture();
        clear_inputs();
        id_valid = 1; id_rs1_addr = 5'd1; id_rs2_addr = 5'd2; id_rd_addr = 5'd9;
        id_rs1_data = 32'd5; id_rs2_data = 32'd7; id_alu_ctrl = 3'b000;
        id_reg_write = 1; id_mem_write = 1;
        step();
        n_total++; if (SrcA !== 32'd5) $display("FAIL plain_srca: got %h want 5", SrcA); else n_pass++;
        n_total++; if (SrcB !== 32'd7) $display("FAIL plain_srcb: got %h want 7", SrcB); else n_pass++;
        n_total++; if (ALUControl !== 3'b000) $display("FAIL plain_aluctrl: got %b want 000", ALUControl); else n_pass++;
        n_total++; if (ex_valid !== 1'b1) $display("FAIL plain_valid: got %b want 1", ex_valid); else n_pass++;
        n_total++; if (ex_rd !== 5'd9) $display("FAIL plain_rd: got %0d want 9", ex_rd); else n_pass++;
        n_total++; if (ex_mem_write !== 1'b1) $display("FAIL plain_memwrite: got %b want 1", ex_mem_write); else n_pass++;
        n_total++; if (ex_store_data !== 32'd7) $display("FAIL plain_store: got %h want 7", ex_store_data); else n_pass++;
        // Invalid slot: control bits must be masked, data still captured
        id_valid = 0; id_reg_write = 1; id_mem_read = 1; id_mem_write = 1; id_alu_ctrl = 3'b110;
        step();
        n_total++; if (ex_valid !== 1'b0) $display("FAIL invalid_valid: got %b want 0", ex_valid); else n_pass++;
        n_total++; if ({ex_reg_write, ex_mem_read, ex_mem_write} !== 3'b000)
            $display("FAIL invalid_ctrl: got %b want 000", {ex_reg_write, ex_mem_read, ex_mem_write}); else n_pass++;
        n_total++; if (ALUControl !== 3'b110) $display("FAIL invalid_aluctrl: got %b want 110", ALUControl); else n_pass++;
    endtask

    task automatic test_forward();
        clear_inputs();
        id_valid = 1; id_rs1_addr = 5'd3; id_rs2_addr = 5'd8; id_rs1_data = 32'h99;
        id_rs2_data = 32'h88;
        step();
        exmem_rd = 5'd3; exmem_reg_write = 1; exmem_result = 32'h11;
        memwb_rd = 5'd3; memwb_reg_write = 1; memwb_result = 32'h22;
        #1;
        n_total++; if (SrcA !== 32'h11) $display("FAIL fwd_exmem_prio: got %h want 11", SrcA); else n_pass++;
        n_total++; if (SrcB !== 32'h88) $display("FAIL fwd_b_nomatch: got %h want 88", SrcB); else n_pass++;
        exmem_reg_write = 0;
        #1;
        n_total++; if (SrcA !== 32'h22) $display("FAIL fwd_memwb: got %h want 22", SrcA); else n_pass++;
        memwb_rd = 5'd8;
        #1;
        n_total++; if (SrcA !== 32'h99) $display("FAIL fwd_none: got %h want 99", SrcA); else n_pass++;
        n_total++; if (SrcB !== 32'h22) $display("FAIL fwd_b_memwb: got %h want 22", SrcB); else n_pass++;
        // x0 source: never forwarded even when writers target x0
        id_rs1_addr = 5'd0; id_rs1_data = 32'h33; id_rs2_addr = 5'd0; id_rs2_data = 32'h44;
        exmem_rd = 5'd0; exmem_reg_write = 1; memwb_rd = 5'd0; memwb_reg_write = 1;
        step();
        n_total++; if (SrcA !== 32'h33) $display("FAIL fwd_x0_a: got %h want 33", SrcA); else n_pass++;
        n_total++; if (SrcB !== 32'h44) $display("FAIL fwd_x0_b: got %h want 44", SrcB); else n_pass++;
        clear_inputs();
    endtask

    task automatic test_load_use();
        clear_inputs();
        // lw x4 enters EX
        id_valid = 1; id_rd_addr = 5'd4; id_mem_read = 1; id_reg_write = 1; id_rs1_addr = 5'd2;
        step();
        // Dependent instruction in ID
        id_mem_read = 0; id_rd_addr = 5'd7; id_rs1_addr = 5'd1; id_rs2_addr = 5'd4;
        id_rs2_data = 32'hAB;
        #1;
        n_total++; if (load_use_hold !== 1'b1) $display("FAIL lu_hold: got %b want 1", load_use_hold); else n_pass++;
        step();
        n_total++; if (ex_valid !== 1'b0) $display("FAIL lu_bubble_valid: got %b want 0", ex_valid); else n_pass++;
        n_total++; if (ex_reg_write !== 1'b0) $display("FAIL lu_bubble_rw: got %b want 0", ex_reg_write); else n_pass++;
        n_total++; if (load_use_hold !== 1'b0) $display("FAIL lu_release: got %b want 0", load_use_hold); else n_pass++;
        step();
        n_total++; if (ex_valid !== 1'b1) $display("FAIL lu_recapture_valid: got %b want 1", ex_valid); else n_pass++;
        n_total++; if (ex_rd !== 5'd7) $display("FAIL lu_recapture_rd: got %0d want 7", ex_rd); else n_pass++;
        n_total++; if (SrcB !== 32'hAB) $display("FAIL lu_recapture_srcb: got %h want ab", SrcB); else n_pass++;
        // Load to x0 never causes a hold
        id_rd_addr = 5'd0; id_mem_read = 1; id_rs2_addr = 5'd5;
        step();
        id_mem_read = 0; id_rs1_addr = 5'd0; id_rs2_addr = 5'd0;
        #1;
        n_total++; if (load_use_hold !== 1'b0) $display("FAIL lu_x0: got %b want 0", load_use_hold); else n_pass++;
        clear_inputs();
    endtask

    task automatic test_stall_flush();
        clear_inputs();
        id_valid = 1; id_rs1_addr = 5'd6; id_rs1_data = 32'h10; id_rd_addr = 5'd2;
        id_alu_ctrl = 3'b101; id_reg_write = 1;
        step();
        stall = 1;
        for (int i = 0; i < 2; i++) begin
            id_rs1_data = 32'h20 + i; id_rd_addr = 5'd9 + i[4:0]; id_alu_ctrl = 3'b010;
            id_rs1_addr = 5'd11;
            step();
            n_total++; if (SrcA !== 32'h10) $display("FAIL stall_srca[%0d]: got %h want 10", i, SrcA); else n_pass++;
            n_total++; if (ex_rd !== 5'd2) $display("FAIL stall_rd[%0d]: got %0d want 2", i, ex_rd); else n_pass++;
            n_total++; if (ALUControl !== 3'b101) $display("FAIL stall_aluctrl[%0d]: got %b want 101", i, ALUControl); else n_pass++;
        end
        // Forwarding keeps working while stalled
        exmem_rd = 5'd6; exmem_reg_write = 1; exmem_result = 32'hCAFE;
        #1;
        n_total++; if (SrcA !== 32'hCAFE) $display("FAIL stall_fwd: got %h want cafe", SrcA); else n_pass++;
        exmem_reg_write = 0;
        flush = 1;
        step();
        n_total++; if (ex_valid !== 1'b0) $display("FAIL flush_valid: got %b want 0", ex_valid); else n_pass++;
        n_total++; if (ex_reg_write !== 1'b0) $display("FAIL flush_rw: got %b want 0", ex_reg_write); else n_pass++;
        n_total++; if (SrcA !== 32'h0) $display("FAIL flush_srca: got %h want 0", SrcA); else n_pass++;
        n_total++; if (ex_rd !== 5'd0) $display("FAIL flush_rd: got %0d want 0", ex_rd); else n_pass++;
        clear_inputs();
    endtask

    task automatic test_src_select();
        clear_inputs();
        id_valid = 1; id_alu_src_a = 1; id_alu_src_b = 1; id_pc = 32'h100; id_imm = 32'hFFFF_FFF0;
        id_rs1_addr = 5'd1; id_rs1_data = 32'h66; id_rs2_addr = 5'd5; id_rs2_data = 32'h77;
        id_mem_write = 1;
        step();
        exmem_rd = 5'd5; exmem_reg_write = 1; exmem_result = 32'h55;
        #1;
        n_total++; if (SrcA !== 32'h100) $display("FAIL sel_srca: got %h want 100", SrcA); else n_pass++;
        n_total++; if (SrcB !== 32'hFFFF_FFF0) $display("FAIL sel_srcb: got %h want fffffff0", SrcB); else n_pass++;
        n_total++; if (ex_store_data !== 32'h55) $display("FAIL sel_store: got %h want 55", ex_store_data); else n_pass++;
        clear_inputs();
    endtask

    task automatic test_async_reset();
        clear_inputs();
        id_valid = 1; id_rs1_data = 32'h5A; id_reg_write = 1;
        step();
        n_total++; if (ex_valid !== 1'b1) $display("FAIL ar_pre_valid: got %b want 1", ex_valid); else n_pass++;
        #2 rst_n = 0;
        #1;
        n_total++; if (ex_valid !== 1'b0) $display("FAIL ar_valid: got %b want 0", ex_valid); else n_pass++;
        n_total++; if (SrcA !== 32'h0) $display("FAIL ar_srca: got %h want 0", SrcA); else n_pass++;
        // Reset overrides a stall across an edge
        stall = 1;
        step();
        n_total++; if (ex_valid !== 1'b0) $display("FAIL ar_hold_valid: got %b want 0", ex_valid); else n_pass++;
        #1 rst_n = 1;
        stall = 0; id_rs1_data = 32'h6B;
        step();
        n_total++; if (ex_valid !== 1'b1) $display("FAIL ar_after_valid: got %b want 1", ex_valid); else n_pass++;
        n_total++; if (SrcA !== 32'h6B) $display("FAIL ar_after_srca: got %h want 6b", SrcA); else n_pass++;
        clear_inputs();
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        rst_n = 0;
        clear_inputs();
        test_reset();
        test_plain_capture();
        test_forward();
        test_load_use();
        test_stall_flush();
        test_src_select();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
